vector_memory_responder: RTL and testbench
==========================================

VECTOR_MEMORY_RESPONDER -- requirements
Module: vector_memory_responder

Interface
REQ-001 Parameter NO_OF_UNITS, default 8, meaning elements per row (lanes).
REQ-002 Parameter ELEMENT_WIDTH, default 32, meaning bits per element.
REQ-003 Parameter DEPTH, default 64, meaning number of rows (total/NO_OF_UNITS).
REQ-004 Parameter ADDR_WIDTH, default 32, meaning width of all address ports.
REQ-005 Port list: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- preload_start  in  1  begin bulk load.
- preload_valid  in  1  preload row present.
- preload_data  in  NO_OF_UNITS*ELEMENT_WIDTH  preload row.
- preload_ready  out  1  row accepted this cycle when high with valid.
- preload_done  out  1  one-cycle pulse after the last row.
- rd_en  in  1  read request.
- rd_address  in  ADDR_WIDTH  read row.
- rd_data  out  NO_OF_UNITS*ELEMENT_WIDTH  registered read row.
- rd_valid  out  1  rd_data valid.
- wr_enable  in  1  write request.
- wr_address  in  ADDR_WIDTH  write row.
- wr_data  in  NO_OF_UNITS*ELEMENT_WIDTH  write row.
- prev_we  in  1  snapshot rd_data into prev register.
- prev_data  out  NO_OF_UNITS*ELEMENT_WIDTH  previous-iteration row.
- clear  in  1  iteration end; invalidate contents.
- addr_err  out  1  sticky out-of-range flag.

Function
REQ-006 FSM states: IDLE, PRELOAD, RUN.
REQ-007 IDLE->PRELOAD on preload_start; PRELOAD->RUN once DEPTH rows are accepted; RUN->PRELOAD on preload_start; other states hold.
REQ-008 PRELOAD: preload_ready=1; each valid&ready cycle writes row at an internal counter (0..DEPTH-1) and sets that row's valid bit; counter increments.
REQ-009 The last accepted row produces preload_done=1 for exactly one cycle and the transition to RUN on the same edge; the counter returns to 0.
REQ-010 preload_ready is 0 outside PRELOAD.
REQ-011 RUN: wr_enable with wr_address<DEPTH writes the row and sets its valid bit on that edge.
REQ-012 RUN: rd_en with rd_address<DEPTH gives rd_data and rd_valid=1 one cycle later; rows whose valid bit is clear read as all zeros.
REQ-013 Write-first: a same-cycle read and write to the same row returns wr_data.
REQ-014 rd_valid=0 and rd_data holds its value when rd_en=0 or the state is not RUN.
REQ-015 wr_enable outside RUN is ignored.
REQ-016 Out of range (address>=DEPTH) on an enabled read or write: the access is suppressed, addr_err is set (sticky), and a read returns rd_valid=1 with zero data.
REQ-017 prev_we latches the current rd_data register into prev_data on that edge; prev_data holds otherwise.
REQ-018 clear on any edge:
- zeroes all valid bits and addr_err;
- aborts PRELOAD to IDLE and resets the preload counter;
- RUN stays RUN;
- clear has priority over same-cycle writes and preload.
REQ-019 Same-cycle clear and rd_en: the read returns zeros with rd_valid=1.
REQ-020 Address comparisons use the full ADDR_WIDTH, with no truncation.

Reset
REQ-021 reset low, asynchronously:
- state=IDLE, preload counter=0;
- all valid bits=0;
- rd_data=0, rd_valid=0, prev_data=0;
- preload_ready=0, preload_done=0, addr_err=0.
REQ-022 Storage array contents are not reset; the valid bits mask them.
REQ-023 Deassertion mid-stream restarts from IDLE; no partial preload is retained.

Structure
REQ-024 A shared package holds the FSM state enum, the NO_OF_UNITS and ELEMENT_WIDTH defaults, and the row-type width constant.
REQ-025 One sub-module, vector_row_ram: a single-write, single-registered-read row RAM without reset. Valid bits, FSM, bypass and error logic stay in the top level.

Verification
REQ-026 Preload 64 rows with value=row index in every lane, then read row 5 -> the cycle after request shows rd_valid=1 and all lanes 5; preload_done pulsed once after row 63.
REQ-027 RUN: write row 10 = 0xDEADBEEF in every lane while reading row 10 the same cycle -> next cycle rd_data is 0xDEADBEEF in every lane.
REQ-028 Read address 64 -> rd_valid=1, data 0, addr_err=1 and remains 1 until clear.
REQ-029 Preload, then clear, then read row 3 -> zeros; write row 3 = 7, then read -> 7.
REQ-030 Read row 2 (=2), pulse prev_we, then read row 9 -> prev_data stays 2 while rd_data=9.
REQ-031 Assert reset low mid-preload after 20 rows, then release -> IDLE, preload_ready=0; reading after a new full preload returns the new data.

Source files
------------

// File: rtl/vector_memory_responder_pkg.sv
// rtl/vector_memory_responder_pkg.sv - shared types and defaults for the vector memory responder
package vector_memory_responder_pkg;

    localparam int DEF_NO_OF_UNITS   = 8;
    localparam int DEF_ELEMENT_WIDTH = 32;
    localparam int DEF_ROW_WIDTH     = DEF_NO_OF_UNITS * DEF_ELEMENT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRELOAD = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Which source drives rd_data for the most recent read response
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_BYP  = 2'd2
    } rd_src_e;

endpackage

// File: rtl/vector_memory_responder_ram.sv
// rtl/vector_memory_responder_ram.sv - single-write, registered-read row RAM with no reset
module vector_row_ram #(
    parameter int ROW_WIDTH = 256,
    parameter int DEPTH     = 64,
    parameter int IW        = 6
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [IW-1:0]        waddr_i,
    input  logic [ROW_WIDTH-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [IW-1:0]        raddr_i,
    output logic [ROW_WIDTH-1:0] rdata_o
);

    logic [ROW_WIDTH-1:0] mem_q [DEPTH];
    logic [ROW_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_memory_responder.sv
// rtl/vector_memory_responder.sv - preloadable row memory with valid masking, bypass and range checking
module vector_memory_responder
    import vector_memory_responder_pkg::*;
#(
    parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
    parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int DEPTH         = 64,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 preload_start,
    input  logic                                 preload_valid,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] preload_data,
    output logic                                 preload_ready,
    output logic                                 preload_done,
    input  logic                                 rd_en,
    input  logic [ADDR_WIDTH-1:0]                rd_address,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] rd_data,
    output logic                                 rd_valid,
    input  logic                                 wr_enable,
    input  logic [ADDR_WIDTH-1:0]                wr_address,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] wr_data,
    input  logic                                 prev_we,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] prev_data,
    input  logic                                 clear,
    output logic                                 addr_err
);

    localparam int RW = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [IW-1:0]         LAST_ROW = IW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    rd_src_e         src_q, src_d;
    logic [RW-1:0]   byp_q, byp_d;
    logic [RW-1:0]   prev_q;
    logic            rd_valid_q, rd_valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            in_run, in_pre, pre_acc, rd_act, wr_act, rd_ok, wr_ok, bypass;
    logic [IW-1:0]   rd_idx, wr_idx;
    logic            ram_we, ram_re;
    logic [IW-1:0]   ram_waddr;
    logic [RW-1:0]   ram_wdata, ram_rdata;

    // Range checks use the full address so high bits never alias onto real rows
    assign in_run  = (state_q == ST_RUN);
    assign in_pre  = (state_q == ST_PRELOAD);
    assign pre_acc = in_pre && preload_valid && !clear;
    assign rd_act  = in_run && rd_en;
    assign wr_act  = in_run && wr_enable;
    assign rd_ok   = (rd_address < DEPTH_A);
    assign wr_ok   = (wr_address < DEPTH_A);
    assign rd_idx  = rd_address[IW-1:0];
    assign wr_idx  = wr_address[IW-1:0];
    assign bypass  = wr_act && wr_ok && (wr_address == rd_address);

    assign ram_we    = pre_acc || (wr_act && wr_ok && !clear);
    assign ram_waddr = in_pre ? cnt_q : wr_idx;
    assign ram_wdata = in_pre ? preload_data : wr_data;
    assign ram_re    = rd_act && rd_ok && !clear && !bypass && valid_q[rd_idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        src_d      = src_q;
        byp_d      = byp_q;
        rd_valid_d = rd_act;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (preload_start && !clear) begin
                    state_d = ST_PRELOAD;
                    cnt_d   = '0;
                end
            end
            ST_PRELOAD: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (pre_acc) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (preload_start && !clear) begin
                    state_d = ST_PRELOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (clear) begin
            valid_d = '0;
        end else if (ram_we) begin
            valid_d[ram_waddr] = 1'b1;
        end

        if (rd_act) begin
            if (clear || !rd_ok) begin
                src_d = SRC_ZERO;
            end else if (bypass) begin
                src_d = SRC_BYP;
                byp_d = wr_data;
            end else if (valid_q[rd_idx]) begin
                src_d = SRC_RAM;
            end else begin
                src_d = SRC_ZERO;
            end
        end

        if (clear) begin
            err_d = 1'b0;
        end else if ((rd_act && !rd_ok) || (wr_act && !wr_ok)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            src_q      <= SRC_ZERO;
            byp_q      <= '0;
            prev_q     <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            src_q      <= src_d;
            byp_q      <= byp_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (prev_we) begin
                prev_q <= rd_data;
            end
        end
    end

    vector_row_ram #(
        .ROW_WIDTH (RW),
        .DEPTH     (DEPTH),
        .IW        (IW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    // The RAM output register is unreset; the source select masks it until a real read lands
    always_comb begin
        case (src_q)
            SRC_RAM: rd_data = ram_rdata;
            SRC_BYP: rd_data = byp_q;
            default: rd_data = '0;
        endcase
    end

    assign rd_valid      = rd_valid_q;
    assign prev_data     = prev_q;
    assign preload_ready = in_pre;
    assign preload_done  = done_q;
    assign addr_err      = err_q;

endmodule

// File: tb/tb_vector_memory_responder.sv
// tb/tb_vector_memory_responder.sv - self-checking bench with an array-based reference model
module tb_vector_memory_responder;

    localparam int NU = 8;
    localparam int EW = 32;
    localparam int DEPTH = 64;
    localparam int AW = 32;
    localparam int RW = NU * EW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          preload_start = 1'b0, preload_valid = 1'b0;
    logic [RW-1:0] preload_data = '0;
    logic          preload_ready, preload_done;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_address = '0;
    logic [RW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_enable = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [RW-1:0] wr_data = '0;
    logic          prev_we = 1'b0;
    logic [RW-1:0] prev_data;
    logic          clear = 1'b0;
    logic          addr_err;

    always #5 clk = ~clk;

    vector_memory_responder #(
        .NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .preload_start(preload_start), .preload_valid(preload_valid), .preload_data(preload_data),
        .preload_ready(preload_ready), .preload_done(preload_done),
        .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data),
        .prev_we(prev_we), .prev_data(prev_data), .clear(clear), .addr_err(addr_err)
    );

    int errors = 0;
    int checks = 0;

    logic [RW-1:0] m_mem [DEPTH];
    bit            m_valid [DEPTH];
    logic [RW-1:0] m_rd = '0;
    logic [RW-1:0] m_prev = '0;
    bit            m_err = 1'b0;

    function automatic logic [RW-1:0] rep(input logic [EW-1:0] v);
        return {NU{v}};
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int i = 0; i < NU; i++) r[i*EW +: EW] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_rd = '0;
        m_prev = '0;
        m_err = 1'b0;
    endtask

    // One RUN-state cycle: model computes the response from the rules, then the DUT is compared
    task automatic run_cycle(input string tag, input bit re, input logic [AW-1:0] ra,
                             input bit we, input logic [AW-1:0] wa, input logic [RW-1:0] wd,
                             input bit clr, input bit pw);
        rd_en = re; rd_address = ra; wr_enable = we; wr_address = wa; wr_data = wd;
        clear = clr; prev_we = pw;
        if (pw) m_prev = m_rd;
        if (re) begin
            if (clr || ra >= DEPTH) m_rd = '0;
            else if (we && wa == ra) m_rd = wd;
            else m_rd = m_valid[ra] ? m_mem[ra] : '0;
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            m_err = 1'b0;
        end else begin
            if (we && wa < DEPTH) begin
                m_mem[wa] = wd;
                m_valid[wa] = 1'b1;
            end
            if ((re && ra >= DEPTH) || (we && wa >= DEPTH)) m_err = 1'b1;
        end
        step();
        rd_en = 1'b0; wr_enable = 1'b0; clear = 1'b0; prev_we = 1'b0;
        chk({tag, ".rd_valid"}, RW'(rd_valid), RW'(re));
        chk({tag, ".rd_data"}, rd_data, m_rd);
        chk({tag, ".addr_err"}, RW'(addr_err), RW'(m_err));
        chk({tag, ".prev_data"}, prev_data, m_prev);
    endtask

    task automatic do_preload(input bit use_rnd);
        logic [RW-1:0] d;
        preload_start = 1'b1;
        step();
        preload_start = 1'b0;
        chk("pre.ready", RW'(preload_ready), RW'(1));
        for (int r = 0; r < DEPTH; r++) begin
            d = use_rnd ? rnd_row() : rep(EW'(r));
            preload_valid = 1'b1;
            preload_data = d;
            m_mem[r] = d;
            m_valid[r] = 1'b1;
            step();
            if (r < DEPTH - 1) chk("pre.done_early", RW'(preload_done), RW'(0));
        end
        preload_valid = 1'b0;
        chk("pre.done_pulse", RW'(preload_done), RW'(1));
        chk("pre.ready_off", RW'(preload_ready), RW'(0));
        step();
        chk("pre.done_once", RW'(preload_done), RW'(0));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_valid[i] = 1'b0;
        end
        step(); step();
        chk("rst.rd_data", rd_data, '0);
        chk("rst.rd_valid", RW'(rd_valid), RW'(0));
        chk("rst.prev", prev_data, '0);
        chk("rst.ready", RW'(preload_ready), RW'(0));
        chk("rst.done", RW'(preload_done), RW'(0));
        chk("rst.err", RW'(addr_err), RW'(0));
        reset = 1'b1;
        step();

        do_preload(1'b0);
        run_cycle("rd5", 1, 5, 0, 0, '0, 0, 0);
        chk("rd5.lanes", rd_data, rep(32'd5));
        run_cycle("idle_hold", 0, 0, 0, 0, '0, 0, 0);
        run_cycle("wf10", 1, 10, 1, 10, rep(32'hDEADBEEF), 0, 0);
        chk("wf10.lanes", rd_data, rep(32'hDEADBEEF));

        run_cycle("rd2", 1, 2, 0, 0, '0, 0, 0);
        run_cycle("prev_we", 0, 0, 0, 0, '0, 0, 1);
        run_cycle("rd9", 1, 9, 0, 0, '0, 0, 0);
        chk("rd9.prev2", prev_data, rep(32'd2));
        chk("rd9.data9", rd_data, rep(32'd9));

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] ra, wa;
            bit same;
            ra = AW'($urandom_range(0, DEPTH + 6));
            same = ($urandom_range(0, 3) == 0);
            wa = same ? ra : AW'($urandom_range(0, DEPTH + 6));
            run_cycle("rand", bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 1)), wa,
                      rnd_row(), 1'b0, ($urandom_range(0, 4) == 0));
        end

        run_cycle("oob_rd", 1, 64, 0, 0, '0, 0, 0);
        chk("oob_rd.err", RW'(addr_err), RW'(1));
        run_cycle("err_sticky", 0, 0, 0, 0, '0, 0, 0);
        run_cycle("trunc_rd", 1, 32'h8000_0002, 0, 0, '0, 0, 0);
        run_cycle("oob_wr", 0, 0, 1, 32'h0000_0043, rep(32'd99), 0, 0);
        run_cycle("rd3_kept", 1, 3, 0, 0, '0, 0, 0);
        run_cycle("clear", 0, 0, 0, 0, '0, 1, 0);
        chk("clear.err", RW'(addr_err), RW'(0));

        run_cycle("rd3_zero", 1, 3, 0, 0, '0, 0, 0);
        chk("rd3_zero.lanes", rd_data, '0);
        run_cycle("wr3", 0, 0, 1, 3, rep(32'd7), 0, 0);
        run_cycle("rd3_seven", 1, 3, 0, 0, '0, 0, 0);
        chk("rd3_seven.lanes", rd_data, rep(32'd7));
        run_cycle("clr_rd", 1, 3, 0, 0, '0, 1, 0);
        run_cycle("clr_wr", 0, 0, 1, 4, rep(32'd11), 1, 0);
        run_cycle("rd4_zero", 1, 4, 0, 0, '0, 0, 0);

        preload_start = 1'b1;
        step();
        preload_start = 1'b0;
        chk("restart.ready", RW'(preload_ready), RW'(1));
        preload_valid = 1'b1;
        preload_data = rnd_row();
        step(); step(); step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        preload_valid = 1'b0;
        chk("abort.ready", RW'(preload_ready), RW'(0));
        model_reset();
        m_rd = rd_data;
        m_prev = prev_data;

        preload_start = 1'b1;
        step();
        preload_start = 1'b0;
        preload_valid = 1'b1;
        for (int r = 0; r < 20; r++) begin
            preload_data = rnd_row();
            step();
        end
        reset = 1'b0;
        #2;
        chk("arst.ready", RW'(preload_ready), RW'(0));
        chk("arst.rd_data", rd_data, '0);
        chk("arst.prev", prev_data, '0);
        chk("arst.err", RW'(addr_err), RW'(0));
        preload_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        model_reset();
        chk("rel.ready", RW'(preload_ready), RW'(0));
        rd_en = 1'b1;
        rd_address = 0;
        wr_enable = 1'b1;
        wr_address = 1;
        wr_data = rep(32'd55);
        step();
        rd_en = 1'b0;
        wr_enable = 1'b0;
        chk("idle.rd_valid", RW'(rd_valid), RW'(0));
        chk("idle.rd_data", rd_data, '0);
        chk("idle.err", RW'(addr_err), RW'(0));

        do_preload(1'b1);
        for (int i = 0; i < 8; i++) begin
            run_cycle("post_rst", 1, AW'($urandom_range(0, DEPTH - 1)), 0, 0, '0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
